matrix_scanner: RTL and testbench
=================================

MATRIX_SCANNER -- requirements
Module: matrix_scanner

Interface
REQ-001 Parameter NCOL, default 5: number of multiplexed matrix columns.
REQ-002 Parameter DWELL, default 1000: clock cycles each column stays lit; legal range 2..65535.
REQ-003 Port clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port en, input, 1: scan enable; when low, scanning freezes and the display is blanked.
REQ-006 Port wr_valid, input, 1: write request into the shadow buffer.
REQ-007 Port wr_ready, output, 1: the shadow buffer can accept a write.
REQ-008 Port wr_col, input, 3: target column index.
REQ-009 Port wr_f1 and wr_f2, input, 3 each: dot codes; 0 = no dot, 1..7 = row 0..6.
REQ-010 Port commit, input, 1: request to copy shadow into active at the next frame boundary.
REQ-011 Port L, output, 7: row drive, active-low; bit r low when either active code of the lit column equals r+1.
REQ-012 Port C, output, NCOL: column drive, one-hot, active-high.
REQ-013 Port frame_done, output, 1: one-cycle pulse when shadow is copied into active.

Function
REQ-014 A write occurs when wr_valid and wr_ready are both high: shadow[wr_col] takes {wr_f1, wr_f2} on the next edge.
REQ-015 A write with wr_col >= NCOL is accepted but leaves the buffers unchanged.
REQ-016 A commit sets commit_pending; wr_ready stays low while commit_pending is set and high otherwise.
REQ-017 Frame boundary: the last cycle of column NCOL-1 dwell. At that point, if commit_pending is set: copy shadow to active, clear commit_pending, pulse frame_done.
REQ-018 Commit asserted in the same cycle as a frame boundary takes effect at the following boundary, not the current one.
REQ-019 A write and a commit in the same cycle: the write is applied first, then the commit is registered.
REQ-020 Scan FSM has states SCAN and BLANK. In SCAN, a dwell counter counts 0..DWELL-1. At DWELL-1 it goes to BLANK, or, with blanking compiled out, directly to the next column.
REQ-021 The column index wraps from NCOL-1 to 0.
REQ-022 L and C are registered; they show column k's decode from the cycle after column k is entered.
REQ-023 While en is low: dwell counter and column index hold, C = 0, L = 7'h7F; writes and commits still operate.
REQ-024 While en is low, a pending commit waits until scanning resumes and reaches a frame boundary.

Reset
REQ-025 While rst is high: active and shadow buffers cleared to 0, column index 0, dwell counter 0, state SCAN, commit_pending 0.
REQ-026 While rst is high: outputs C = 0, L = 7'h7F, wr_ready = 0, frame_done = 0.
REQ-027 In the first cycle after rst deasserts: wr_ready = 1, scanning starts at column 0, C = one-hot bit 0 the following cycle.
REQ-028 Reset asserted mid-frame or with a commit pending discards the pending commit and all buffer contents.

Configuration
REQ-029 Macro MATRIX_SCANNER_BLANKING_EN defined: each dwell is followed by exactly one BLANK cycle with C = 0 and L = 7'h7F, then the next column is entered; a frame lasts NCOL*(DWELL+1) cycles.
REQ-030 Macro MATRIX_SCANNER_BLANKING_EN undefined: the BLANK state is omitted; a frame lasts NCOL*DWELL cycles.

Structure
REQ-031 Shared package matrix_pkg holds NROW = 7, CODE_W = 3, the default NCOL, and the scan-state enum {SCAN, BLANK}.
REQ-032 Sub-module row_decoder (combinational): two CODE_W codes in, NROW active-low row lines out; instantiated once on the active buffer entry of the current column.

Verification
REQ-033 Reset, then scan with DWELL = 4 and NCOL = 5, blanking off -> C walks 00001, 00010, ..., 10000, 00001, each for 4 cycles; L = 7F throughout.
REQ-034 Write col 2 with f1 = 1, f2 = 7; commit; wait one frame boundary -> frame_done pulses once; during column 2, L = 7'b0111110; other columns L = 7F.
REQ-035 Write col 0 with f1 = 3, f2 = 3, no commit -> display unchanged; wr_ready stays 1.
REQ-036 Commit asserted in the boundary cycle -> frame_done one frame later; wr_ready low the whole interval.
REQ-037 en low for 10 cycles mid-column 3 -> C = 0 and L = 7F; on resume, column 3 completes its remaining dwell.
REQ-038 Blanking on, DWELL = 4 -> one C = 0 cycle between columns, frame = 25 cycles; write to wr_col = 6 -> buffers unchanged.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants and types for the LED dot-matrix column scanner.
// Row codes: 0 = no dot, 1..NROW = row index plus one.
package matrix_pkg;

  localparam int NROW     = 7;
  localparam int CODE_W   = 3;
  localparam int COL_W    = 3;
  localparam int NCOL_DEF = 5;
  localparam int DWELL_W  = 16;

  typedef enum logic [0:0] {
    SCAN  = 1'b0,
    BLANK = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [CODE_W-1:0] f1;
    logic [CODE_W-1:0] f2;
  } entry_t;

endpackage

// File: rtl/row_decoder.sv
// Turns two dot codes into active-low row drive lines.
// A row is pulled low when either code selects it.
module row_decoder
  import matrix_pkg::*;
(
  input  logic [CODE_W-1:0] f1,
  input  logic [CODE_W-1:0] f2,
  output logic [NROW-1:0]   l
);

  always_comb begin
    l = '1;
    for (int r = 0; r < NROW; r++) begin
      if (f1 == CODE_W'(r + 1) || f2 == CODE_W'(r + 1)) begin
        l[r] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/matrix_scanner.sv
// Multiplexed dot-matrix scanner with shadow/active double buffer.
// Define MATRIX_SCANNER_BLANKING_EN for one dark cycle between columns.
module matrix_scanner
  import matrix_pkg::*;
#(
  parameter int NCOL  = NCOL_DEF,
  parameter int DWELL = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [CODE_W-1:0] wr_f1,
  input  logic [CODE_W-1:0] wr_f2,
  input  logic              commit,
  output logic [NROW-1:0]   L,
  output logic [NCOL-1:0]   C,
  output logic              frame_done
);

  entry_t             active [NCOL];
  entry_t             shadow [NCOL];
  logic [COL_W-1:0]   col;
  logic [COL_W-1:0]   col_nxt;
  logic [DWELL_W-1:0] cnt;
  scan_state_e        state;
  logic               pending;
  logic               last_cnt;
  logic               last_col;
  logic               in_scan;
  logic               boundary;
  logic               wr_hit;
  logic [NROW-1:0]    row_l;

  assign last_cnt = cnt == DWELL_W'(DWELL - 1);
  assign last_col = col == COL_W'(NCOL - 1);
  assign col_nxt  = last_col ? '0 : col + COL_W'(1);
  assign in_scan  = state == SCAN;
  assign boundary = en && in_scan && last_cnt && last_col;
  assign wr_ready = !rst && !pending;
  assign wr_hit   = wr_valid && wr_ready &&
                    (32'(wr_col) < NCOL);

  row_decoder u_dec (
    .f1 (active[col].f1),
    .f2 (active[col].f2),
    .l  (row_l)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCOL; i++) begin
        active[i] <= '0;
        shadow[i] <= '0;
      end
      col        <= '0;
      cnt        <= '0;
      state      <= SCAN;
      pending    <= 1'b0;
      C          <= '0;
      L          <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (wr_hit) begin
        shadow[wr_col] <= {wr_f1, wr_f2};
      end
      // pending is sampled before this cycle's commit lands
      if (boundary && pending) begin
        for (int i = 0; i < NCOL; i++) begin
          active[i] <= shadow[i];
        end
        frame_done <= 1'b1;
      end
      if (commit) begin
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
      if (en && in_scan) begin
        C <= NCOL'(1) << col;
        L <= row_l;
      end else begin
        C <= '0;
        L <= '1;
      end
      if (en) begin
        unique case (state)
          SCAN: begin
            if (last_cnt) begin
              cnt <= '0;
`ifdef MATRIX_SCANNER_BLANKING_EN
              state <= BLANK;
`else
              col <= col_nxt;
`endif
            end else begin
              cnt <= cnt + DWELL_W'(1);
            end
          end
          BLANK: begin
            state <= SCAN;
            col   <= col_nxt;
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_matrix_scanner.sv
// Scoreboard bench for matrix_scanner: NCOL=5, DWELL=4.
// Display and frame_done expectations are queued by stimulus.
module tb_matrix_scanner;

  localparam int NCOL  = 5;
  localparam int DWELL = 4;
`ifdef MATRIX_SCANNER_BLANKING_EN
  localparam int BLK = 1;
`else
  localparam int BLK = 0;
`endif
  localparam int SLOT = DWELL + BLK;
  localparam int FR   = NCOL * SLOT;
  localparam int EN0  = 4 * FR + 3 * SLOT + 2;
  localparam int LAST = 6 * FR + 10;

  typedef struct packed {
    logic [NCOL-1:0] c;
    logic [6:0]      l;
  } disp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            wr_valid;
  logic            wr_ready;
  logic [2:0]      wr_col;
  logic [2:0]      wr_f1;
  logic [2:0]      wr_f2;
  logic            commit;
  logic [6:0]      L;
  logic [NCOL-1:0] C;
  logic            frame_done;

  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  disp_t dq[$];
  int    fq[$];

  matrix_scanner #(.NCOL(NCOL), .DWELL(DWELL)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_col     (wr_col),
    .wr_f1      (wr_f1),
    .wr_f2      (wr_f2),
    .commit     (commit),
    .L          (L),
    .C          (C),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int bnd(input int f);
    return f * FR + 4 * SLOT + DWELL - 1;
  endfunction

  task automatic push_frame(input int f);
    logic [NCOL-1:0] one;
    disp_t           d;
    one = 1;
    for (int k = 0; k < NCOL; k++) begin
      d.c = one << k;
      d.l = 7'h7F;
      if (f >= 1 && k == 2) d.l = 7'b0111110;
      if (f >= 4 && k == 0) d.l = 7'b1111011;
      dq.push_back(d);
    end
  endtask

  // monitor: pops on each newly lit column and on frame_done
  logic [NCOL-1:0] last_c = '0;
  logic [6:0]      cur_l  = 7'h7F;
  int              lit    = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (C == '0) begin
        chk("dark_l", {25'd0, L}, 32'h7F);
      end else if (C != last_c) begin
        if (last_c != '0) chk("dwell_len", lit, DWELL);
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL disp_underflow: got C=%b expected none", C);
        end else begin
          disp_t d;
          d = dq.pop_front();
          chk("col_c", {27'd0, C}, {27'd0, d.c});
          chk("col_l", {25'd0, L}, {25'd0, d.l});
          cur_l = d.l;
        end
        last_c = C;
        lit = 1;
      end else begin
        lit++;
        chk("col_l_hold", {25'd0, L}, {25'd0, cur_l});
      end
      if (frame_done) begin
        if (fq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_done_extra: got pulse at %0d expected none",
                   cyc);
        end else begin
          chk("frame_done_cyc", cyc, fq.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1; en = 1; wr_valid = 0; commit = 0;
    wr_col = 0; wr_f1 = 0; wr_f2 = 0;
    repeat (3) @(negedge clk);
    chk("rst_c", {27'd0, C}, 32'd0);
    chk("rst_l", {25'd0, L}, 32'h7F);
    chk("rst_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_fdone", {31'd0, frame_done}, 32'd0);
    rst = 0;
    for (int n = 0; n <= LAST; n++) begin
      if (n > 0) @(negedge clk);
      for (int f = 0; f < 6; f++) begin
        if (n == f * FR + (f == 5 ? 10 : 0)) push_frame(f);
      end
      wr_valid = 0;
      commit   = 0;
      if (n == 1) chk("ready_after_rst", {31'd0, wr_ready}, 32'd1);
      if (n == 5) begin
        chk("ready_wr_a", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1; wr_col = 2; wr_f1 = 1; wr_f2 = 7;
        commit = 1;
        fq.push_back(bnd(0) + 1);
      end
      if (n == 6) chk("ready_pend_a", {31'd0, wr_ready}, 32'd0);
      if (n == bnd(0) + 1)
        chk("ready_free_a", {31'd0, wr_ready}, 32'd1);
      if (n == FR + 5) begin
        chk("ready_wr_b", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1; wr_col = 0; wr_f1 = 3; wr_f2 = 3;
      end
      if (n == FR + 6) chk("ready_no_commit", {31'd0, wr_ready}, 32'd1);
      if (n == FR + 7) begin
        chk("ready_wr_oob", {31'd0, wr_ready}, 32'd1);
        wr_valid = 1; wr_col = 6; wr_f1 = 7; wr_f2 = 7;
      end
      if (n == bnd(2)) begin
        commit = 1;
        fq.push_back(bnd(3) + 1);
      end
      if (n > bnd(2) && n <= bnd(3))
        chk("ready_pend_c", {31'd0, wr_ready}, 32'd0);
      if (n == bnd(3) + 1)
        chk("ready_free_c", {31'd0, wr_ready}, 32'd1);
      if (n == EN0) en = 0;
      if (n == EN0 + 5) begin
        chk("en_low_c", {27'd0, C}, 32'd0);
        chk("en_low_l", {25'd0, L}, 32'h7F);
      end
      if (n == EN0 + 10) en = 1;
    end
    #1;
    chk("disp_left", dq.size(), 0);
    chk("fdone_left", fq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
